// File: rtl/sseg_pkg.sv
// Shared types and active-low segment patterns for the seven-segment scan driver.
package sseg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  bcd_t       value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      unique case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexes four BCD digits onto a common-anode display, snapshotting the
// inputs once per frame so a frame never mixes old and new digits.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int DP_POS        = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  bcd_t          snap [4];
  logic          tick;
  logic          blank;
  bcd_t          cur_digit;
  logic [6:0]    seg_dec;

  assign tick      = (presc == PRESC_LAST);
  assign cur_digit = snap[idx];

  // A digit above the decimal point is blank only if it and every higher digit
  // are zero; invalid codes are non-zero and so stop the blanking.
  always_comb begin
    blank = 1'b0;
    if (BLANK_LEADING != 0 && int'(idx) > DP_POS) begin
      blank = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (j >= int'(idx) && snap[j] != 4'd0) blank = 1'b0;
      end
    end
  end

  bcd_to_sseg u_dec (
    .value (cur_digit),
    .blank (blank),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (tick && idx == 2'd3) begin
        snap[0] <= d0;
        snap[1] <= d1;
        snap[2] <= d2;
        snap[3] <= d3;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_dec;
      dp  <= (int'(idx) == DP_POS) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized bench for sseg_scan_driver against a cycle-count based display model.
module tb_sseg_scan_driver;

  localparam int DIV   = 4;
  localparam int DPP   = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release, and the digits the current frame shows.
  int         edge_n = 0;
  logic [3:0] msnap [4];

  sseg_scan_driver #(
    .REFRESH_DIV   (DIV),
    .DP_POS        (DPP),
    .BLANK_LEADING (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v, input logic blank);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (blank) return 7'b1111111;
    if (v > 4'd9) return 7'b0111111;
    return tab[v];
  endfunction

  // Which digit slot the outputs show after edge k (k counts from 1 after release).
  function automatic int slot_of(input int k);
    return ((k - 1) / DIV) % 4;
  endfunction

  task automatic step();
    int         s;
    logic       blank;
    logic [3:0] exp_an;
    @(posedge clk);
    edge_n++;
    s = slot_of(edge_n);
    blank = (s > DPP);
    for (int j = 0; j < 4; j++)
      if (j >= s && msnap[j] != 4'd0) blank = 1'b0;
    exp_an = 4'b1111;
    exp_an[s] = 1'b0;
    // The frame boundary edge samples whatever d is presented at that edge.
    if (edge_n % FRAME == 0) begin
      msnap[0] = d0; msnap[1] = d1; msnap[2] = d2; msnap[3] = d3;
    end
    #1;
    check("an",  16'(an),  16'(exp_an));
    check("seg", 16'(seg), 16'(seg_of(dut_digit_unused_guard(s), blank)));
    check("dp",  16'(dp),  16'(s == DPP ? 1'b0 : 1'b1));
  endtask

  // Returns the model digit for slot s from the snapshot taken before this edge.
  logic [3:0] prev_snap [4];
  function automatic logic [3:0] dut_digit_unused_guard(input int s);
    return prev_snap[s];
  endfunction

  task automatic step_m();
    for (int j = 0; j < 4; j++) prev_snap[j] = msnap[j];
    step();
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  16'(an),  16'h000F);
    check({tag, "_seg"}, 16'(seg), 16'h007F);
    check({tag, "_dp"},  16'(dp),  16'h0001);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    for (int j = 0; j < 4; j++) msnap[j] = 4'd0;
  endtask

  task automatic set_d(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_m();
  endtask

  logic [3:0] r;

  initial begin
    for (int j = 0; j < 4; j++) begin msnap[j] = '0; prev_snap[j] = '0; end

    // Reset and the all-zero first frame.
    set_d(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_dark("rst");
    release_reset();
    run(FRAME);

    // Scan order and decode with a steady value.
    set_d(4, 3, 2, 1);
    run(2 * FRAME);

    // Tearing: change d0 mid-frame while slot 1 is showing.
    set_d(1, 2, 3, 4);
    run(FRAME);
    run(DIV + 1);
    d0 = 4'd9;
    run(2 * FRAME);

    // Blanking and invalid BCD cases.
    set_d(0, 0, 5, 7);          run(2 * FRAME);
    set_d(0, 8, 0, 0);          run(2 * FRAME);
    set_d(0, 0, 4'hC, 0);       run(2 * FRAME);
    set_d(4'hF, 0, 0, 0);       run(2 * FRAME);
    set_d(0, 4'hA, 0, 0);       run(2 * FRAME);

    // Async reset between edges while slot 2 is showing.
    set_d(3, 1, 4, 1);
    run(FRAME);
    while (slot_of(edge_n + 1) != 2 || (edge_n % DIV) != 1) step_m();
    #2 reset = 1'b1;
    #1 check_dark("arst");
    repeat (2) begin @(posedge clk); #1 check_dark("arst_hold"); end
    release_reset();
    run(2 * FRAME);

    // Random digits, biased toward zeros so blanking is exercised.
    for (int n = 0; n < 150; n++) begin
      r = 4'($urandom_range(0, 3));
      d3 = (r == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      d2 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      d1 = 4'($urandom_range(0, 15));
      d0 = 4'($urandom_range(0, 9));
      run(int'($urandom_range(1, 20)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
